// File: rtl/gpr_seq_pkg.sv
// Shared types and default sizes for the GPR operand sequencer.
// Imported by gpr_seq_alu and gpr_alu_seq.
package gpr_seq_pkg;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_REGS = 10;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MOV = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_FIN  = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  // Ops whose result depends on A alone.
  function automatic logic is_unary(op_e o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_MOV);
  endfunction

endpackage

// File: rtl/gpr_seq_alu.sv
// Combinational ALU for the GPR sequencer.
// (op, a, b) -> (result, carry); registered by the caller.
module gpr_seq_alu
  import gpr_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  // Operation decode; carry is zero for logic ops and MOV.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      OP_MOV: result = a;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gpr_alu_seq.sv
// Multicycle read-A / read-B / exec / write-back sequencer on a GPR port.
// Optional: GPR_SEQ_UNARY_SKIP_EN skips the B read for SHL/SHR/MOV.
module gpr_alu_seq
  import gpr_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rd,
  output logic [ADDR_W-1:0] gpr_addr,
  output logic              gpr_read,
  output logic              gpr_write,
  output logic [DATA_W-1:0] gpr_wdata,
  input  logic [DATA_W-1:0] gpr_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);

`ifdef GPR_SEQ_UNARY_SKIP_EN
  localparam logic SKIP = 1'b1;
`else
  localparam logic SKIP = 1'b0;
`endif

  localparam logic [ADDR_W:0] LIM = NUM_REGS[ADDR_W:0];

  state_e state, state_n;

  op_e               op_q;
  logic [ADDR_W-1:0] ra_q, rb_q, rd_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic              carry_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  logic ra_bad, rb_bad, rd_bad, rb_need, bad;

  // Range check on the live command inputs, decided in IDLE.
  always_comb begin
    ra_bad  = ({1'b0, ra} >= LIM);
    rb_bad  = ({1'b0, rb} >= LIM);
    rd_bad  = ({1'b0, rd} >= LIM);
    rb_need = !(SKIP && is_unary(op_e'(op)));
    bad     = ra_bad || rd_bad || (rb_bad && rb_need);
  end

  gpr_seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .carry  (alu_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next-state sequencing.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start) state_n = bad ? ST_ERR : ST_RD_A;
      ST_RD_A: state_n = (SKIP && is_unary(op_q)) ? ST_EXEC : ST_RD_B;
      ST_RD_B: state_n = ST_EXEC;
      ST_EXEC: state_n = ST_WB;
      ST_WB:   state_n = ST_FIN;
      ST_FIN:  state_n = ST_IDLE;
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Register-file port and status outputs; port idles at zero.
  always_comb begin
    gpr_addr  = '0;
    gpr_read  = 1'b0;
    gpr_write = 1'b0;
    gpr_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_RD_A: begin
        gpr_addr = ra_q;
        gpr_read = 1'b1;
      end
      ST_RD_B: begin
        gpr_addr = rb_q;
        gpr_read = 1'b1;
      end
      ST_WB: begin
        gpr_addr  = rd_q;
        gpr_write = 1'b1;
        gpr_wdata = res_q;
      end
      ST_FIN:  done = 1'b1;
      ST_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Command capture, operand latch, result and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_ADD;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        op_q <= op_e'(op);
        ra_q <= ra;
        rb_q <= rb;
        rd_q <= rd;
      end
      if (state == ST_RD_A) a_q <= gpr_rdata;
      if (state == ST_RD_B) b_q <= gpr_rdata;
      if (state == ST_EXEC) begin
        res_q   <= alu_res;
        carry_q <= alu_c;
      end
      if (state == ST_WB) begin
        flag_z <= (res_q == '0);
        flag_c <= carry_q;
      end
    end
  end

endmodule

// File: tb/tb_gpr_alu_seq.sv
// Randomized bench for gpr_alu_seq with a register-file model
// and an arithmetic reference model.
module tb_gpr_alu_seq;

  localparam int NR = 10;

`ifdef GPR_SEQ_UNARY_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] ra = '0, rb = '0, rd = '0;
  logic [3:0] gpr_addr;
  logic       gpr_read, gpr_write;
  logic [9:0] gpr_wdata;
  wire  [9:0] gpr_rdata;
  logic       busy, done, err, flag_z, flag_c;

  logic [9:0] rf [NR];
  int         ref_rf [NR];
  logic       pre_we = 1'b0;
  int         pre_addr = 0;
  logic [9:0] pre_data = '0;
  int         n_wr_total = 0;

  int n_chk = 0;
  int n_fail = 0;
  int exp_z = 0;
  int exp_c = 0;

  always #5 clk = ~clk;

  gpr_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .ra        (ra),
    .rb        (rb),
    .rd        (rd),
    .gpr_addr  (gpr_addr),
    .gpr_read  (gpr_read),
    .gpr_write (gpr_write),
    .gpr_wdata (gpr_wdata),
    .gpr_rdata (gpr_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .flag_z    (flag_z),
    .flag_c    (flag_c)
  );

  assign gpr_rdata = !gpr_read ? 10'bz :
                     (int'(gpr_addr) < NR) ? rf[gpr_addr] : 10'bx;

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (gpr_write) begin
      n_wr_total <= n_wr_total + 1;
      if (int'(gpr_addr) < NR) rf[gpr_addr] <= gpr_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rw_excl", 32'(gpr_read & gpr_write), 0);
      if (!gpr_read && !gpr_write)
        chk("idle_port", {18'd0, gpr_addr, gpr_wdata}, 0);
    end
  end

  function automatic void alu_model(input int o, input int a, input int b,
                                    output int r, output int c);
    c = 0;
    case (o)
      0: begin r = a + b; c = (r >= 1024) ? 1 : 0; end
      1: begin c = (a < b) ? 1 : 0; r = a - b + 1024; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; c = a / 512; end
      6: begin r = a / 2; c = a % 2; end
      default: r = a;
    endcase
    r = r % 1024;
  endfunction

  task automatic set_reg(input int i, input int v);
    pre_we = 1'b1;
    pre_addr = i;
    pre_data = 10'(v);
    @(negedge clk);
    pre_we = 1'b0;
    ref_rf[i] = v;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the next IDLE.
  task automatic run_cmd(input int o, input int a_i, input int b_i,
                         input int d_i, input bit poke);
    bit un, bad;
    int ea, eb, er, ec, exp_lat, exp_rd;
    int cyc, nrd, nwr, wcyc, rd1, rd2, waddr, wdat;
    un  = (o >= 5);
    bad = (a_i >= NR) || (d_i >= NR) || ((b_i >= NR) && !(SKIP && un));
    er = 0; ec = 0; rd1 = -1; rd2 = -1; waddr = -1; wdat = -1;
    if (!bad) begin
      ea = ref_rf[a_i];
      eb = (b_i < NR) ? ref_rf[b_i] : 0;
      alu_model(o, ea, eb, er, ec);
    end
    exp_lat = bad ? 1 : ((SKIP && un) ? 4 : 5);
    exp_rd  = bad ? 0 : ((SKIP && un) ? 1 : 2);
    start = 1'b1; op = 3'(o); ra = 4'(a_i); rb = 4'(b_i); rd = 4'(d_i);
    cyc = 0; nrd = 0; nwr = 0; wcyc = -1;
    do begin
      @(negedge clk);
      cyc++;
      if (gpr_read) begin
        nrd++;
        if (nrd == 1) rd1 = int'(gpr_addr);
        else rd2 = int'(gpr_addr);
      end
      if (gpr_write) begin
        nwr++; wcyc = cyc; waddr = int'(gpr_addr); wdat = int'(gpr_wdata);
      end
      start = 1'b0;
      if (poke && !bad && cyc == 2) begin
        start = 1'b1; ra = 4'hF; op = 3'd0;
      end
    end while (!done && cyc < 20);
    chk("timeout", 32'(done), 1);
    chk("latency", cyc, exp_lat);
    chk("err", 32'(err), 32'(bad));
    chk("busy_at_done", 32'(busy), 1);
    chk("reads", nrd, exp_rd);
    chk("writes", nwr, bad ? 0 : 1);
    if (!bad) begin
      chk("rd_a_addr", rd1, a_i);
      if (exp_rd == 2) chk("rd_b_addr", rd2, b_i);
      chk("wb_cycle", wcyc, exp_lat - 1);
      chk("wb_addr", waddr, d_i);
      chk("wb_data", wdat, er);
      ref_rf[d_i] = er;
      exp_z = (er == 0) ? 1 : 0;
      exp_c = ec;
      chk("rf_dest", 32'(rf[d_i]), er);
    end
    chk("flag_z", 32'(flag_z), exp_z);
    chk("flag_c", 32'(flag_c), exp_c);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
  endtask

  task automatic reset_mid_op();
    int wr0;
    start = 1'b1; op = 3'd0; ra = 4'd1; rb = 4'd2; rd = 4'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr0 = n_wr_total;
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_write", 32'(gpr_write), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_z = 0; exp_c = 0;
    chk("rst_no_wr", n_wr_total, wr0);
    chk("rst_rf6", 32'(rf[6]), ref_rf[6]);
    chk("rst_flag_z", 32'(flag_z), 0);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_flags", {30'd0, flag_z, flag_c}, 0);
    chk("reset_port", {16'd0, gpr_addr, gpr_read, gpr_write, gpr_wdata}, 0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_reg(i, int'($urandom_range(0, 1023)));

    set_reg(1, 'h005); set_reg(2, 'h003);
    run_cmd(0, 1, 2, 3, 1'b0);
    set_reg(1, 'h3FF); set_reg(2, 'h001);
    run_cmd(0, 1, 2, 4, 1'b0);
    run_cmd(1, 2, 1, 5, 1'b0);
    run_cmd(0, 10, 1, 2, 1'b0);
    run_cmd(2, 1, 11, 2, 1'b0);
    reset_mid_op();
    run_cmd(0, 1, 2, 6, 1'b0);
    run_cmd(2, 1, 2, 7, 1'b1);
    run_cmd(3, 2, 1, 8, 1'b0);
    set_reg(1, 'h201);
    run_cmd(5, 1, 2, 1, 1'b0);
    run_cmd(6, 3, 12, 9, 1'b0);
    run_cmd(1, 3, 3, 3, 1'b0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 5) == 0)
        set_reg(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 1023)));
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 11)),
              int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
              bit'($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < NR; i++) chk("rf_final", 32'(rf[i]), ref_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
